uart_tx_scheduler: RTL and testbench

Round-robin scheduler that shares one UART transmitter among `N_REQ` requesters. It arbitrates pending byte requests and drives the transmitter's `P_Data` / `D_Valid` / `Parity_EN` / `Parity_TYP` inputs. It holds those inputs stable for the whole frame, tracks the transmitter's `busy` output to detect frame completion, and reports per-requester grant/done plus an acknowledge-timeout error. It sits directly in front of the UART TX top level.

---
 rtl/uart_tx_scheduler.sv | 117 +++++++++++
 tb/tb_uart_tx_scheduler.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter sharing one UART transmitter among N_REQ requesters
module uart_tx_scheduler #(
  parameter int P_Data_Width = 8,
  parameter int N_REQ        = 4,
  parameter int ACK_TIMEOUT  = 4
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic [N_REQ-1:0]              Req,
  input  logic [N_REQ*P_Data_Width-1:0] Req_Data,
  input  logic [N_REQ-1:0]              Req_Par_EN,
  input  logic [N_REQ-1:0]              Req_Par_TYP,
  input  logic                          busy,
  output logic [N_REQ-1:0]              Grant,
  output logic [N_REQ-1:0]              Done,
  output logic                          Err,
  output logic [P_Data_Width-1:0]       P_Data,
  output logic                          D_Valid,
  output logic                          Parity_EN,
  output logic                          Parity_TYP
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
  state_t                  state_q, state_d;
  logic [IW-1:0]           last_q, last_d, idx_q, idx_d, win, cand;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [N_REQ-1:0]        grant_q, grant_d, done_q, done_d;
  logic                    err_q, err_d, dv_q, dv_d, pen_q, pen_d, ptyp_q, ptyp_d, hit;
  logic [P_Data_Width-1:0] data_q, data_d;
  // Walk downward from the farthest slot so the nearest set bit after last_q wins.
  always_comb begin
    win  = last_q;
    hit  = 1'b0;
    cand = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = IW'((int'(last_q) + k) % N_REQ);
      if (Req[cand]) begin
        win = cand;
        hit = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    pen_d   = pen_q;
    ptyp_d  = ptyp_q;
    grant_d = '0;
    done_d  = '0;
    err_d   = 1'b0;
    dv_d    = 1'b0;
    case (state_q)
      IDLE: if (!busy && hit) begin
        state_d      = ISSUE;
        idx_d        = win;
        data_d       = Req_Data[int'(win)*P_Data_Width +: P_Data_Width];
        pen_d        = Req_Par_EN[win];
        ptyp_d       = Req_Par_TYP[win];
        grant_d[win] = 1'b1;
        dv_d         = 1'b1;
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
        cnt_d   = '0;
      end
      WAIT_BUSY: if (busy) state_d = WAIT_DONE;
      else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end else cnt_d = cnt_q + 1'b1;
      WAIT_DONE: if (!busy) begin
        done_d[idx_q] = 1'b1;
        last_d        = idx_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      last_q  <= IW'(N_REQ - 1);
      idx_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      pen_q   <= 1'b0;
      ptyp_q  <= 1'b0;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      pen_q   <= pen_d;
      ptyp_q  <= ptyp_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      dv_q    <= dv_d;
    end
  end
  assign Grant      = grant_q;
  assign Done       = done_q;
  assign Err        = err_q;
  assign P_Data     = data_q;
  assign D_Valid    = dv_q;
  assign Parity_EN  = pen_q;
  assign Parity_TYP = ptyp_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed checks of arbitration order, frame hold, timeout and reset abort
module tb_uart_tx_scheduler;
  logic        Clk = 1'b0, Reset = 1'b1, busy = 1'b0;
  logic [3:0]  Req = '0, Req_Par_EN = '0, Req_Par_TYP = '0;
  logic [31:0] Req_Data = '0;
  logic [3:0]  Grant, Done;
  logic        Err, D_Valid, Parity_EN, Parity_TYP;
  logic [7:0]  P_Data;
  int          passed = 0, total = 0;
  logic [31:0] base_data = 32'h13121110;
  logic [3:0]  base_pen = 4'b0101, base_ptyp = 4'b0011;

  uart_tx_scheduler dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Req_Data(Req_Data), .Req_Par_EN(Req_Par_EN),
    .Req_Par_TYP(Req_Par_TYP), .busy(busy), .Grant(Grant), .Done(Done), .Err(Err),
    .P_Data(P_Data), .D_Valid(D_Valid), .Parity_EN(Parity_EN), .Parity_TYP(Parity_TYP)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic serve(input int i);
    logic [31:0] d;
    tick();
    d = base_data;
    chk($sformatf("grant_%0d", i), 32'(Grant), 32'(4'b1 << i));
    chk($sformatf("dvalid_%0d", i), 32'(D_Valid), 1);
    chk($sformatf("pdata_%0d", i), 32'(P_Data), 32'(d[i*8 +: 8]));
    chk($sformatf("paren_%0d", i), 32'(Parity_EN), 32'(base_pen[i]));
    chk($sformatf("partyp_%0d", i), 32'(Parity_TYP), 32'(base_ptyp[i]));
    busy = 1'b1;
    tick();
    tick();
    tick();
    busy = 1'b0;
    tick();
    chk($sformatf("done_%0d", i), 32'(Done), 32'(4'b1 << i));
  endtask

  initial begin
    tick();
    tick();
    Reset = 1'b0;
    chk("rst_grant", 32'(Grant), 0);
    chk("rst_done", 32'(Done), 0);
    chk("rst_err", 32'(Err), 0);
    chk("rst_dvalid", 32'(D_Valid), 0);
    chk("rst_pdata", 32'(P_Data), 0);
    chk("rst_par", {30'd0, Parity_EN, Parity_TYP}, 0);
    // single request with data held through the frame
    Req = 4'b0001;
    Req_Data = 32'h000000A5;
    Req_Par_EN = 4'b0001;
    Req_Par_TYP = 4'b0000;
    tick();
    chk("single_grant", 32'(Grant), 32'h1);
    chk("single_dvalid", 32'(D_Valid), 1);
    chk("single_pdata", 32'(P_Data), 32'hA5);
    chk("single_paren", 32'(Parity_EN), 1);
    chk("single_partyp", 32'(Parity_TYP), 0);
    Req = '0;
    Req_Data = '0;
    Req_Par_EN = '0;
    busy = 1'b1;
    tick();
    chk("single_dv_pulse", 32'(D_Valid), 0);
    chk("single_grant_pulse", 32'(Grant), 0);
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("single_hold", 32'(P_Data), 32'hA5);
      chk("single_nodone", 32'(Done), 0);
    end
    busy = 1'b0;
    tick();
    chk("single_done", 32'(Done), 32'h1);
    chk("single_hold_end", 32'(P_Data), 32'hA5);
    chk("single_paren_hold", 32'(Parity_EN), 1);
    tick();
    chk("single_done_pulse", 32'(Done), 0);
    chk("single_idle_hold", 32'(P_Data), 32'hA5);
    // fairness: all requesters continuously pending
    Req_Data = base_data;
    Req_Par_EN = base_pen;
    Req_Par_TYP = base_ptyp;
    Req = 4'b1111;
    serve(1);
    serve(2);
    serve(3);
    serve(0);
    serve(1);
    Req = '0;
    // priority rotation: serve 2, then 0 beats 2
    Req = 4'b0100;
    serve(2);
    Req = 4'b0101;
    serve(0);
    serve(2);
    Req = '0;
    // ack timeout with busy never rising
    Req = 4'b1000;
    tick();
    chk("to_grant", 32'(Grant), 32'h8);
    Req = '0;
    for (int n = 1; n <= 4; n++) begin
      tick();
      chk($sformatf("to_noerr_%0d", n), 32'(Err), 0);
    end
    tick();
    chk("to_err", 32'(Err), 1);
    chk("to_nodone", 32'(Done), 0);
    Req = 4'b1001;
    tick();
    chk("to_err_pulse", 32'(Err), 0);
    chk("to_regrant", 32'(Grant), 32'h8);
    Req = '0;
    busy = 1'b1;
    tick();
    tick();
    busy = 1'b0;
    tick();
    chk("to_regrant_done", 32'(Done), 32'h8);
    // reset while in WAIT_DONE
    Req = 4'b0100;
    tick();
    chk("rm_grant", 32'(Grant), 32'h4);
    Req = '0;
    busy = 1'b1;
    tick();
    tick();
    tick();
    chk("rm_pdata_held", 32'(P_Data), 32'h12);
    Reset = 1'b1;
    busy = 1'b0;
    tick();
    chk("rm_done", 32'(Done), 0);
    chk("rm_pdata", 32'(P_Data), 0);
    chk("rm_outs", {27'd0, Grant, D_Valid}, 0);
    chk("rm_err_par", {29'd0, Err, Parity_EN, Parity_TYP}, 0);
    Reset = 1'b0;
    tick();
    chk("rm_no_late_done", 32'(Done), 0);
    Req = 4'b0011;
    serve(0);
    Req = '0;
    // external busy blocks issue in IDLE
    busy = 1'b1;
    Req = 4'b0010;
    tick();
    chk("eb_hold_1", 32'(D_Valid), 0);
    tick();
    chk("eb_hold_2", 32'(D_Valid), 0);
    busy = 1'b0;
    tick();
    chk("eb_grant", 32'(Grant), 32'h2);
    chk("eb_dvalid", 32'(D_Valid), 1);
    Req = '0;
    busy = 1'b1;
    tick();
    tick();
    busy = 1'b0;
    tick();
    chk("eb_done", 32'(Done), 32'h2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
